result_serializer: RTL and testbench
====================================

RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 Parameter WIDTH, default 5, SHALL set the bit width of each expression result.
REQ-002 Parameter DEPTH, default 4, power of two and at least 2, SHALL set the number of buffered result triplets.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL indicate that a result triplet is presented.
REQ-006 in_ready  output  1  SHALL indicate that the block can accept a triplet.
REQ-007 in_b, in_c, in_d  input  WIDTH each  SHALL carry the three macro-expanded expression results.
REQ-008 out_valid  output  1  SHALL indicate that out_data is valid.
REQ-009 out_ready  input  1  SHALL indicate that the consumer accepts out_data.
REQ-010 out_data  output  WIDTH  SHALL carry the current serialized result.
REQ-011 out_sel  output  2  SHALL identify the field on out_data: 0=b, 1=c, 2=d; 3 is never driven.
REQ-012 out_mis  output  1  SHALL flag that the head triplet had unequal fields.
REQ-013 err_cnt  output  8  SHALL count accepted mismatching triplets.

Function
REQ-014 in_ready SHALL equal NOT full, where full means DEPTH triplets are stored; there is no same-cycle pass-through when full.
REQ-015 A triplet SHALL be written when in_valid and in_ready are both high at a rising edge, together with mis = (in_b != in_c) OR (in_c != in_d).
REQ-016 err_cnt SHALL increment on each accepted triplet with mis=1 and saturate at 255.
REQ-017 The FSM SHALL have states IDLE, EMIT_B, EMIT_C and EMIT_D.
REQ-018 out_valid SHALL be high exactly in EMIT_B, EMIT_C and EMIT_D.
REQ-019 out_sel SHALL be 0, 1 or 2 respectively in those states.
REQ-020 out_data SHALL be the selected field of the FIFO head; out_mis SHALL be the mis bit of the head.
REQ-021 IDLE SHALL go to EMIT_B when the FIFO is non-empty; first out_valid is therefore 1 clock after the accepting edge.
REQ-022 EMIT_B SHALL go to EMIT_C, and EMIT_C SHALL go to EMIT_D, only on out_valid AND out_ready; otherwise the state and outputs SHALL be held stable.
REQ-023 On handshake in EMIT_D, the head SHALL be popped and the FSM SHALL go to EMIT_B if the stored count before the pop exceeds 1, otherwise to IDLE.
REQ-024 A push in the same cycle as a pop SHALL be accepted (if not full) and SHALL be seen by IDLE on the next cycle.
REQ-025 Simultaneous push and pop SHALL leave the count unchanged.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 With no pop, at most DEPTH consecutive triplets SHALL be accepted.
REQ-028 Sustained throughput SHALL be one field per clock, i.e. 3 clocks per triplet, when out_ready is held high.

Reset
REQ-029 Asserting rst_n low SHALL immediately clear the state to IDLE, both pointers, the count and err_cnt, even mid-triplet; a partially emitted triplet SHALL be discarded.
REQ-030 During reset the outputs SHALL be out_valid=0, out_data=0, out_sel=0, out_mis=0, err_cnt=0 and in_ready=1.
REQ-031 Deassertion of reset SHALL take effect at the next rising edge of clk.

Structure
REQ-032 A package result_pkg SHALL hold the WIDTH default, the out_sel encodings (SEL_B, SEL_C, SEL_D) and the FSM state enum.
REQ-033 Storage SHALL be a sub-module result_fifo: a parameterized (DEPTH x (3*WIDTH+1)) synchronous FIFO with full/empty/count outputs.
REQ-034 The FSM, the mismatch compare and err_cnt SHALL reside in result_serializer.

Verification
REQ-035 Push one triplet (6,6,6) with out_ready=1 -> out_sel 0,1,2 with out_data 6,6,6 on 3 consecutive cycles, out_mis=0, err_cnt=0, then IDLE.
REQ-036 Push (6,7,6) -> out_mis=1 for all three fields; err_cnt=1.
REQ-037 Push 5 triplets back-to-back with out_ready=0 -> in_ready drops after the 4th; the 5th is held until the first pop; then all 5 emerge in order.
REQ-038 Toggle out_ready randomly during emission -> out_data and out_sel stay stable while stalled; no field is lost or duplicated.
REQ-039 Assert rst_n low in EMIT_C with 2 triplets buffered -> out_valid drops immediately; after release, nothing is emitted and in_ready=1.
REQ-040 Push 300 mismatching triplets -> err_cnt saturates at 255.

Source files
------------

// File: rtl/result_pkg.sv
// Shared definitions for the result serializer: default field width,
// out_sel encodings and the emission FSM state type.
package result_pkg;

    localparam int WIDTH_DEF = 5;

    localparam logic [1:0] SEL_B = 2'd0;
    localparam logic [1:0] SEL_C = 2'd1;
    localparam logic [1:0] SEL_D = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT_B = 2'd1,
        EMIT_C = 2'd2,
        EMIT_D = 2'd3
    } state_e;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO holding packed result triplets; pointers wrap modulo DEPTH.
// Storage is not reset, only pointers and count are.
module result_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/result_serializer.sv
// Buffers (b, c, d) result triplets and emits them one field per beat,
// flagging triplets whose fields disagree and counting them in err_cnt.
module result_serializer
    import result_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    output logic             out_mis,
    output logic [7:0]       err_cnt,
    output state_e           fsm_state
);

    localparam int ENTRY_W = 3 * WIDTH + 1;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits for ready, and data is held while valid && !ready.
    logic               push;
    logic               pop;
    logic               mis_in;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [WIDTH-1:0]   h_b, h_c, h_d;
    logic               h_mis;
    state_e             state;

    assign mis_in    = (in_b != in_c) || (in_c != in_d);
    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign pop       = (state == EMIT_D) && out_ready;
    assign fsm_state = state;

    assign h_b   = head[WIDTH-1:0];
    assign h_c   = head[2*WIDTH-1:WIDTH];
    assign h_d   = head[3*WIDTH-1:2*WIDTH];
    assign h_mis = head[3*WIDTH];

    result_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({mis_in, in_d, in_c, in_b}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_sel   <= SEL_B;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state     <= EMIT_B;
                        out_valid <= 1'b1;
                        out_sel   <= SEL_B;
                    end
                end
                EMIT_B: begin
                    if (out_ready) begin
                        state   <= EMIT_C;
                        out_sel <= SEL_C;
                    end
                end
                EMIT_C: begin
                    if (out_ready) begin
                        state   <= EMIT_D;
                        out_sel <= SEL_D;
                    end
                end
                EMIT_D: begin
                    // Count is sampled before this pop; a push landing now is picked up via IDLE.
                    if (out_ready) begin
                        out_sel <= SEL_B;
                        if (fifo_count > CNT_W'(1)) begin
                            state <= EMIT_B;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_sel   <= SEL_B;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (push && mis_in && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    always_comb begin
        out_data = '0;
        out_mis  = 1'b0;
        if (out_valid) begin
            out_mis = h_mis;
            case (out_sel)
                SEL_B:   out_data = h_b;
                SEL_C:   out_data = h_c;
                default: out_data = h_d;
            endcase
        end
    end

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_result_serializer;
    import result_pkg::*;

    localparam int W = 5;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic         mis;
        logic [W-1:0] d;
        logic [W-1:0] c;
        logic [W-1:0] b;
    } trip_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_b = '0, in_c = '0, in_d = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;
    logic         out_mis;
    logic [7:0]   err_cnt;
    state_e       fsm_state;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    result_serializer #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_mis   (out_mis),
        .err_cnt   (err_cnt),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Queue of stored triplets plus the index of the next field to hand out
    // from the head (-1: nothing on offer).
    trip_t m_q[$];
    int    m_phase = -1;
    int    m_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_phase = -1;
            m_err   = 0;
        end else begin
            int    sz;
            bit    do_push;
            trip_t t;
            sz      = m_q.size();
            do_push = in_valid && (sz < DEPTH);
            if (m_phase >= 0) begin
                if (out_ready) begin
                    if (m_phase < 2) m_phase++;
                    else begin
                        void'(m_q.pop_front());
                        m_phase = (sz > 1) ? 0 : -1;
                    end
                end
            end else if (sz > 0) begin
                m_phase = 0;
            end
            if (do_push) begin
                t.b = in_b; t.c = in_c; t.d = in_d;
                t.mis = (in_b != in_c) || (in_c != in_d);
                m_q.push_back(t);
                if (t.mis && m_err < 255) m_err++;
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [W-1:0] seen_q[$];
    logic [W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, (m_q.size() < DEPTH) ? 1 : 0);
            chk("err_cnt", err_cnt, m_err);
            chk("out_valid", out_valid, (m_phase >= 0) ? 1 : 0);
            if (m_phase >= 0) begin
                trip_t h;
                h = m_q[0];
                chk("out_sel", out_sel, m_phase);
                chk("out_data", out_data, (m_phase == 0) ? h.b : (m_phase == 1) ? h.c : h.d);
                chk("out_mis", out_mis, h.mis);
            end else if (!rst_n) begin
                chk("rst_out_data", out_data, 0);
                chk("rst_out_sel", out_sel, 0);
                chk("rst_out_mis", out_mis, 0);
            end
            if (rst_n && out_valid && out_ready) seen_q.push_back(out_data);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_held(input logic [W-1:0] b, input logic [W-1:0] c, input logic [W-1:0] d);
        bit ok;
        bit done;
        done = 1'b0;
        in_valid = 1'b1; in_b = b; in_c = c; in_d = d;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_drained();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(posedge clk);
            #1;
            if (m_q.size() == 0 && m_phase < 0) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    task automatic expect_field(input string name, input int sel, input int data, input int mis);
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_sel"}, out_sel, sel);
        chk({name, "_data"}, out_data, data);
        chk({name, "_mis"}, out_mis, mis);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n_valid_seen;
        trip_t tt[5];

        @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_err_cnt", err_cnt, 0);
        chk("reset_out_data", out_data, 0);
        chk_en = 1'b1;
        rst_n = 1'b1;

        // single matching triplet
        out_ready = 1'b1;
        push_held(5'd6, 5'd6, 5'd6);
        @(negedge clk);
        chk("lat_idle", out_valid, 0);
        expect_field("t666_b", 0, 6, 0);
        expect_field("t666_c", 1, 6, 0);
        expect_field("t666_d", 2, 6, 0);
        @(negedge clk);
        chk("t666_done", out_valid, 0);
        chk("t666_err", err_cnt, 0);
        @(posedge clk); #1;

        // single mismatching triplet
        push_held(5'd6, 5'd7, 5'd6);
        @(negedge clk);
        expect_field("t676_b", 0, 6, 1);
        expect_field("t676_c", 1, 7, 1);
        expect_field("t676_d", 2, 6, 1);
        chk("t676_err", err_cnt, 1);
        @(posedge clk); #1;
        wait_drained();

        // fill to full with the consumer stalled, fifth held until a pop
        tt[0] = '{mis: 1'b1, b: 5'd1,  c: 5'd2,  d: 5'd3};
        tt[1] = '{mis: 1'b0, b: 5'd4,  c: 5'd4,  d: 5'd4};
        tt[2] = '{mis: 1'b1, b: 5'd7,  c: 5'd0,  d: 5'd7};
        tt[3] = '{mis: 1'b0, b: 5'd9,  c: 5'd9,  d: 5'd9};
        tt[4] = '{mis: 1'b1, b: 5'd10, c: 5'd11, d: 5'd12};
        out_ready = 1'b0;
        seen_q.delete();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(tt[i].b);
            exp_q.push_back(tt[i].c);
            exp_q.push_back(tt[i].d);
        end
        for (int i = 0; i < 4; i++) push_held(tt[i].b, tt[i].c, tt[i].d);
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        fork
            push_held(tt[4].b, tt[4].c, tt[4].d);
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drained();
        chk("order_count", seen_q.size(), 15);
        while (exp_q.size() > 0 && seen_q.size() > 0) begin
            chk("order_field", seen_q.pop_front(), exp_q.pop_front());
        end
        chk("order_err", err_cnt, 4);

        // random traffic with random consumer stalls
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] b;
            b = W'($urandom_range(0, 31));
            in_b = b;
            in_c = ($urandom_range(0, 1) == 1) ? b : W'($urandom_range(0, 31));
            in_d = ($urandom_range(0, 1) == 1) ? b : W'($urandom_range(0, 31));
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drained();

        // reset in the middle of a triplet with a second one buffered
        out_ready = 1'b0;
        push_held(5'd3, 5'd3, 5'd4);
        push_held(5'd8, 5'd8, 5'd8);
        for (int i = 0; i < 20 && fsm_state != EMIT_B; i++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_sel", out_sel, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_data", out_data, 0);
        chk("rst_mid_sel", out_sel, 0);
        chk("rst_mid_mis", out_mis, 0);
        chk("rst_mid_err", err_cnt, 0);
        chk("rst_mid_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        n_valid_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) n_valid_seen++;
        end
        chk("post_rst_no_emit", n_valid_seen, 0);
        chk("post_rst_ready", in_ready, 1);

        // error counter saturation
        @(posedge clk); #1;
        for (int i = 0; i < 300; i++) begin
            push_held(W'(i % 32), W'((i + 1) % 32), W'(i % 32));
            if (i == 254) chk("err_at_255", err_cnt, 255);
        end
        wait_drained();
        chk("err_saturated", err_cnt, 255);

        do_reset();
        chk("final_err_clear", err_cnt, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
